// File: rtl/pharmacy_heap_queue.sv
// rtl/pharmacy_heap_queue.sv - min-priority (ID, key) queue held as a 1-based register heap
// Sifting advances one heap level per cycle; list streams heap slots in array order.
module pharmacy_heap_queue #(
   parameter int ID_W  = 5,
   parameter int KEY_W = 8,
   parameter int DEPTH = 10,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   input  logic [ID_W-1:0]  cmd_id,
   input  logic [KEY_W-1:0] cmd_key,
   output logic             cmd_ready,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_id,
   output logic [KEY_W-1:0] out_key,
   output logic             out_last,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam logic [1:0] CMD_LIST = 2'b00;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_INS  = 2'b10;
   localparam logic [1:0] CMD_DEL  = 2'b11;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN, LIST} state_t;

   state_t state, state_next;

   // Slot 0 is never a live entry; it only absorbs reads for absent children.
   logic [ID_W-1:0]  id_mem  [0:DEPTH];
   logic [KEY_W-1:0] key_mem [0:DEPTH];

   logic [CNT_W-1:0] pos, idx, parent, l_idx, r_idx, child;
   logic [CNT_W:0]   l, r;
   logic             has_l, has_r, swap_up, swap_down, accept;

   assign cmd_ready = rst_n && (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign full      = (count == DEPTH_C);
   assign empty     = (count == '0);

   always_comb begin
      parent    = pos >> 1;
      swap_up   = (pos > ONE) && (key_mem[pos] < key_mem[parent]);
      l         = {pos, 1'b0};
      r         = l + 1'b1;
      has_l     = (l <= {1'b0, count});
      has_r     = (r <= {1'b0, count});
      l_idx     = has_l ? l[CNT_W-1:0] : '0;
      r_idx     = has_r ? r[CNT_W-1:0] : '0;
      // Left child wins ties so equal keys stay put.
      child     = (has_r && (key_mem[r_idx] < key_mem[l_idx])) ? r_idx : l_idx;
      swap_down = has_l && (key_mem[child] < key_mem[pos]);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (cmd)
                  CMD_INS:  if (!full)       state_next = SIFT_UP;
                  CMD_DEL:  if (count > TWO) state_next = SIFT_DOWN;
                  CMD_LIST: if (count > ONE) state_next = LIST;
                  default:  state_next = IDLE;
               endcase
            end
         end
         SIFT_UP:   if (!swap_up)      state_next = IDLE;
         SIFT_DOWN: if (!swap_down)    state_next = IDLE;
         LIST:      if (idx == count)  state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count     <= '0;
         pos       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_id    <= '0;
         out_key   <= '0;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  case (cmd)
                     CMD_INS: begin
                        if (full) begin
                           err <= 1'b1;
                        end else begin
                           id_mem[count + ONE]  <= cmd_id;
                           key_mem[count + ONE] <= cmd_key;
                           count                <= count + ONE;
                           pos                  <= count + ONE;
                        end
                     end
                     CMD_DEL: begin
                        if (empty) begin
                           err <= 1'b1;
                        end else begin
                           out_valid  <= 1'b1;
                           out_last   <= 1'b1;
                           out_id     <= id_mem[ONE];
                           out_key    <= key_mem[ONE];
                           id_mem[ONE]  <= id_mem[count];
                           key_mem[ONE] <= key_mem[count];
                           count      <= count - ONE;
                           pos        <= ONE;
                        end
                     end
                     CMD_LIST: begin
                        // The first beat leaves straight from IDLE so beats start next cycle.
                        if (!empty) begin
                           out_valid <= 1'b1;
                           out_last  <= (count == ONE);
                           out_id    <= id_mem[ONE];
                           out_key   <= key_mem[ONE];
                           idx       <= TWO;
                        end
                     end
                     default: count <= '0;
                  endcase
               end
            end
            SIFT_UP: begin
               if (swap_up) begin
                  id_mem[pos]     <= id_mem[parent];
                  key_mem[pos]    <= key_mem[parent];
                  id_mem[parent]  <= id_mem[pos];
                  key_mem[parent] <= key_mem[pos];
                  pos             <= parent;
               end
            end
            SIFT_DOWN: begin
               if (swap_down) begin
                  id_mem[pos]    <= id_mem[child];
                  key_mem[pos]   <= key_mem[child];
                  id_mem[child]  <= id_mem[pos];
                  key_mem[child] <= key_mem[pos];
                  pos            <= child;
               end
            end
            LIST: begin
               out_valid <= 1'b1;
               out_last  <= (idx == count);
               out_id    <= id_mem[idx];
               out_key   <= key_mem[idx];
               if (idx != count) idx <= idx + ONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pharmacy_heap_queue.sv
// tb/tb_pharmacy_heap_queue.sv - scoreboard bench for pharmacy_heap_queue
module tb_pharmacy_heap_queue;

   localparam int ID_W  = 5;
   localparam int KEY_W = 8;
   localparam int DEPTH = 10;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] C_LIST = 2'b00;
   localparam logic [1:0] C_CLR  = 2'b01;
   localparam logic [1:0] C_INS  = 2'b10;
   localparam logic [1:0] C_DEL  = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd = 2'b00;
   logic [ID_W-1:0]  cmd_id = '0;
   logic [KEY_W-1:0] cmd_key = '0;
   logic             cmd_ready, out_valid, out_last, full, empty, err;
   logic [ID_W-1:0]  out_id;
   logic [KEY_W-1:0] out_key;
   logic [CNT_W-1:0] count;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [KEY_W-1:0] key;
      logic             last;
   } beat_t;

   beat_t sb[$];
   beat_t exp_beat;
   int    checks = 0;
   int    errors = 0;
   int    err_seen = 0;
   int    err_base;

   logic [ID_W-1:0]  m_id[$];
   logic [KEY_W-1:0] m_key[$];

   pharmacy_heap_queue #(.ID_W(ID_W), .KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_id(cmd_id), .cmd_key(cmd_key), .cmd_ready(cmd_ready),
      .out_valid(out_valid), .out_id(out_id), .out_key(out_key),
      .out_last(out_last), .count(count), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (err) err_seen++;
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", 32'(out_valid), 32'd0);
         end else begin
            exp_beat = sb.pop_front();
            check("beat_id",   32'(out_id),   32'(exp_beat.id));
            check("beat_key",  32'(out_key),  32'(exp_beat.key));
            check("beat_last", 32'(out_last), 32'(exp_beat.last));
         end
      end
   end

   task automatic send(input logic [1:0] c, input logic [ID_W-1:0] id, input logic [KEY_W-1:0] key);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd       = c;
      cmd_id    = id;
      cmd_key   = key;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic push(input logic [ID_W-1:0] id, input logic [KEY_W-1:0] key, input logic last);
      sb.push_back('{id: id, key: key, last: last});
   endtask

   task automatic model_del();
      int best = 0;
      for (int i = 1; i < m_key.size(); i++)
         if (m_key[i] < m_key[best]) best = i;
      push(m_id[best], m_key[best], 1'b1);
      m_id.delete(best);
      m_key.delete(best);
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_count",     32'(count),     32'd0);
      check("rst_empty",     32'(empty),     32'd1);
      check("rst_full",      32'(full),      32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_ready_low", 32'(cmd_ready), 32'd0);
      rst_n = 1'b1;

      // Basic insert / list / delete
      send(C_INS, 5'd1, 8'd30);
      send(C_INS, 5'd2, 8'd10);
      send(C_INS, 5'd3, 8'd20);
      push(5'd2, 8'd10, 1'b0); push(5'd1, 8'd30, 1'b0); push(5'd3, 8'd20, 1'b1);
      send(C_LIST, 5'd0, 8'd0);
      drain("t1_drain");
      check("t1_count", 32'(count), 32'd3);

      push(5'd2, 8'd10, 1'b1);
      send(C_DEL, 5'd0, 8'd0);
      drain("t2_del_drain");
      check("t2_count", 32'(count), 32'd2);
      push(5'd3, 8'd20, 1'b0); push(5'd1, 8'd30, 1'b1);
      send(C_LIST, 5'd0, 8'd0);
      drain("t2_list_drain");

      // Overfill then drain in priority order
      send(C_CLR, 5'd0, 8'd0);
      err_base = err_seen;
      for (int i = 0; i < 11; i++) begin
         logic [KEY_W-1:0] k;
         k = KEY_W'(((i * 7) % 11) * 10 + 5);
         if (i < DEPTH) begin
            m_id.push_back(ID_W'(i + 1));
            m_key.push_back(k);
         end
         send(C_INS, ID_W'(i + 1), k);
      end
      drain("t3_ins_drain");
      check("t3_err_pulses", 32'(err_seen - err_base), 32'd1);
      check("t3_full",  32'(full),  32'd1);
      check("t3_count", 32'(count), 32'd10);
      for (int i = 0; i < DEPTH; i++) begin
         model_del();
         send(C_DEL, 5'd0, 8'd0);
      end
      drain("t3_del_drain");
      check("t3_empty", 32'(empty), 32'd1);

      // Empty queue: delete errors, list yields nothing
      err_base = err_seen;
      send(C_DEL, 5'd0, 8'd0);
      send(C_LIST, 5'd0, 8'd0);
      @(negedge clk);
      check("t4_ready_after_list", 32'(cmd_ready), 32'd1);
      drain("t4_drain");
      check("t4_err_pulses", 32'(err_seen - err_base), 32'd1);

      // Equal keys never reorder
      send(C_INS, 5'd4, 8'd50);
      send(C_INS, 5'd5, 8'd50);
      send(C_INS, 5'd6, 8'd50);
      push(5'd4, 8'd50, 1'b0); push(5'd5, 8'd50, 1'b0); push(5'd6, 8'd50, 1'b1);
      send(C_LIST, 5'd0, 8'd0);
      drain("t5_drain");
      send(C_CLR, 5'd0, 8'd0);
      check("t5_clr_count", 32'(count), 32'd0);
      check("t5_clr_empty", 32'(empty), 32'd1);

      // Reset during SIFT_DOWN
      send(C_INS, 5'd20, 8'd5);
      send(C_INS, 5'd21, 8'd15);
      send(C_INS, 5'd22, 8'd25);
      send(C_INS, 5'd23, 8'd35);
      push(5'd20, 8'd5, 1'b1);
      send(C_DEL, 5'd0, 8'd0);
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      check("t6a_out_valid", 32'(out_valid), 32'd0);
      check("t6a_count",     32'(count),     32'd0);
      check("t6a_ready",     32'(cmd_ready), 32'd0);
      rst_n = 1'b1;
      #1 check("t6a_ready_after", 32'(cmd_ready), 32'd1);
      check("t6a_sb", 32'(sb.size()), 32'd0);

      // Reset during LIST
      send(C_INS, 5'd10, 8'd40);
      send(C_INS, 5'd11, 8'd30);
      send(C_INS, 5'd12, 8'd20);
      send(C_INS, 5'd13, 8'd10);
      push(5'd13, 8'd10, 1'b0);
      send(C_LIST, 5'd0, 8'd0);
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      check("t6b_out_valid", 32'(out_valid), 32'd0);
      check("t6b_count",     32'(count),     32'd0);
      rst_n = 1'b1;
      check("t6b_sb", 32'(sb.size()), 32'd0);

      send(C_INS, 5'd7, 8'd9);
      push(5'd7, 8'd9, 1'b1);
      send(C_LIST, 5'd0, 8'd0);
      drain("t6_final_drain");
      check("t6_count", 32'(count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
